// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller_if
//  Description : Bundle of the pipeline-side hazard inputs and the controller's
//                stall/flush/forward outputs. "master" is the pipeline datapath
//                (drives register fields and stage status, consumes controls);
//                "slave" is the hazard controller.
//  Signals     : rs1_d/rs2_d     decode source registers
//                rs1_e/rs2_e     execute source registers
//                rd_e/mem_read_e execute destination / load flag
//                pc_src_e        branch/jump taken in execute
//                rd_m/reg_write_m, rd_w/reg_write_w  later-stage writers
//                imem_ready      instruction memory has data this cycle
//                stall_f/stall_d/flush_d/flush_e     pipeline register controls
//                forward_a_e/forward_b_e             execute operand selects
//                stall_count     saturating stall-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             mem_read_e;
  logic             pc_src_e;
  logic [4:0]       rd_m;
  logic             reg_write_m;
  logic [4:0]       rd_w;
  logic             reg_write_w;
  logic             imem_ready;
  logic             stall_f;
  logic             stall_d;
  logic             flush_d;
  logic             flush_e;
  logic [1:0]       forward_a_e;
  logic [1:0]       forward_b_e;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mem_read_e, pc_src_e,
           rd_m, reg_write_m, rd_w, reg_write_w, imem_ready,
    input  stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e,
           stall_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mem_read_e, pc_src_e,
           rd_m, reg_write_m, rd_w, reg_write_w, imem_ready,
    output stall_f, stall_d, flush_d, flush_e, forward_a_e, forward_b_e,
           stall_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stall, flush and forward sequencer for the 5-stage pipeline.
//                Holds fetch and flushes decode/execute for BOOT_CYCLES after
//                reset, resolves load-use / taken-branch / imem-miss hazards,
//                selects execute-stage forwarding and counts stall cycles.
//  Ports       : clk   - system clock (rising edge)
//                rst_n - asynchronous active-low reset
//                hz    - slave side of pipeline_hazard_controller_if
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int BOOT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    IWAIT = 2'd2
  } state_t;

  localparam logic [3:0]       c_boot_last = 4'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_boot_cnt;
  logic [CNT_W-1:0] r_stall_count;

  logic             w_load_use;
  logic             w_miss;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_flush_d;
  logic             w_flush_e;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  assign w_load_use = hz.mem_read_e && (hz.rd_e != 5'd0) &&
                      ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  assign w_miss     = !hz.imem_ready;

  // State, boot counter and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_boot_cnt    <= 4'd0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == BOOT) begin
        r_boot_cnt <= r_boot_cnt + 4'd1;
      end
      // Boot-time fetch hold is not a hazard stall, so it is not counted
      if ((r_state != BOOT) && w_stall_f && (r_stall_count != c_cnt_max)) begin
        r_stall_count <= r_stall_count + c_cnt_one;
      end
    end
  end

  // Next state and pipeline controls
  always_comb begin
    w_next_state = r_state;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_fwd_a      = 2'b00;
    w_fwd_b      = 2'b00;

    if (r_state == BOOT) begin
      w_stall_f = 1'b1;
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
      if (r_boot_cnt == c_boot_last) begin
        w_next_state = RUN;
      end
    end else begin
      // RUN and IWAIT share equations; the label only tracks the miss wait
      if (hz.pc_src_e) begin
        // Redirect squashes everything younger, so a pending miss is moot
        w_flush_d    = 1'b1;
        w_flush_e    = 1'b1;
        w_next_state = RUN;
      end else if (w_load_use) begin
        w_stall_f    = 1'b1;
        w_stall_d    = 1'b1;
        w_flush_e    = 1'b1;
        w_next_state = w_miss ? IWAIT : RUN;
      end else if (w_miss) begin
        w_stall_f    = 1'b1;
        w_flush_d    = 1'b1;
        w_next_state = IWAIT;
      end else begin
        w_next_state = RUN;
      end

      // Memory stage is younger, so it takes precedence; x0 is never forwarded
      if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs1_e)) begin
        w_fwd_a = 2'b10;
      end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_e)) begin
        w_fwd_a = 2'b01;
      end

      if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == hz.rs2_e)) begin
        w_fwd_b = 2'b10;
      end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_e)) begin
        w_fwd_b = 2'b01;
      end
    end
  end

  assign hz.stall_f     = w_stall_f;
  assign hz.stall_d     = w_stall_d;
  assign hz.flush_d     = w_flush_d;
  assign hz.flush_e     = w_flush_e;
  assign hz.forward_a_e = w_fwd_a;
  assign hz.forward_b_e = w_fwd_b;
  assign hz.stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed, table-driven bench for pipeline_hazard_controller.
//                dut0 uses the default counter width; dut1 mirrors the same
//                stimulus with a 4-bit counter to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int ST_BOOT  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_IWAIT = 2;

  logic clk;
  logic rst_n;

  pipeline_hazard_controller_if #(.CNT_W(16)) hz0 ();
  pipeline_hazard_controller_if #(.CNT_W(4))  hz1 ();

  pipeline_hazard_controller #(.BOOT_CYCLES(4), .CNT_W(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz0)
  );

  pipeline_hazard_controller #(.BOOT_CYCLES(4), .CNT_W(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz1)
  );

  assign hz1.rs1_d       = hz0.rs1_d;
  assign hz1.rs2_d       = hz0.rs2_d;
  assign hz1.rs1_e       = hz0.rs1_e;
  assign hz1.rs2_e       = hz0.rs2_e;
  assign hz1.rd_e        = hz0.rd_e;
  assign hz1.mem_read_e  = hz0.mem_read_e;
  assign hz1.pc_src_e    = hz0.pc_src_e;
  assign hz1.rd_m        = hz0.rd_m;
  assign hz1.reg_write_m = hz0.reg_write_m;
  assign hz1.rd_w        = hz0.rd_w;
  assign hz1.reg_write_w = hz0.reg_write_w;
  assign hz1.imem_ready  = hz0.imem_ready;

  logic [1:0] st0;
  assign st0 = dut0.r_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int rs1_d, rs2_d, rs1_e, rs2_e, rd_e, mr, pc, rd_m, wm, rd_w, ww, rdy;
    int sf, sd, fd, fe, fa, fb, st;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;
  int   exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ctl(input string nm, input int sf, input int sd, input int fd,
                         input int fe, input int fa, input int fb);
    chk({nm, ".stall_f"}, 32'(hz0.stall_f), 32'(sf));
    chk({nm, ".stall_d"}, 32'(hz0.stall_d), 32'(sd));
    chk({nm, ".flush_d"}, 32'(hz0.flush_d), 32'(fd));
    chk({nm, ".flush_e"}, 32'(hz0.flush_e), 32'(fe));
    chk({nm, ".fwd_a"},   32'(hz0.forward_a_e), 32'(fa));
    chk({nm, ".fwd_b"},   32'(hz0.forward_b_e), 32'(fb));
  endtask

  task automatic drive(input int rs1_d, input int rs2_d, input int rs1_e, input int rs2_e,
                       input int rd_e, input int mr, input int pc, input int rd_m,
                       input int wm, input int rd_w, input int ww, input int rdy);
    hz0.rs1_d       = 5'(rs1_d);
    hz0.rs2_d       = 5'(rs2_d);
    hz0.rs1_e       = 5'(rs1_e);
    hz0.rs2_e       = 5'(rs2_e);
    hz0.rd_e        = 5'(rd_e);
    hz0.mem_read_e  = 1'(mr);
    hz0.pc_src_e    = 1'(pc);
    hz0.rd_m        = 5'(rd_m);
    hz0.reg_write_m = 1'(wm);
    hz0.rd_w        = 5'(rd_w);
    hz0.reg_write_w = 1'(ww);
    hz0.imem_ready  = 1'(rdy);
  endtask

  // One hazard cycle: apply at negedge, check controls, then check the
  // registered effects (state, stall counter) at the following negedge.
  task automatic run_vec(input vec_t v);
    drive(v.rs1_d, v.rs2_d, v.rs1_e, v.rs2_e, v.rd_e, v.mr, v.pc,
          v.rd_m, v.wm, v.rd_w, v.ww, v.rdy);
    #1;
    chk_ctl(v.nm, v.sf, v.sd, v.fd, v.fe, v.fa, v.fb);
    @(negedge clk);
    if (v.sf != 0) exp_cnt++;
    chk({v.nm, ".state"}, 32'(st0), 32'(v.st));
    chk({v.nm, ".stall_count"}, 32'(hz0.stall_count), 32'(exp_cnt));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_cnt = 0;

    //           name        rs1d rs2d rs1e rs2e rde mr pc rdm wm rdw ww rdy  sf sd fd fe fa fb st
    tbl.push_back('{"lu_rs1",   5,  0,  0,  0,  5, 1, 0,  0, 0,  0, 0, 1,   1, 1, 0, 1, 0, 0, ST_RUN});
    tbl.push_back('{"bubble",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"ld_x0",    0,  0,  0,  0,  0, 1, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"lu_rs2",   0,  9,  0,  0,  9, 1, 0,  0, 0,  0, 0, 1,   1, 1, 0, 1, 0, 0, ST_RUN});
    tbl.push_back('{"no_load",  5,  0,  0,  0,  5, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"pc_prio",  5,  0,  0,  0,  5, 1, 1,  0, 0,  0, 0, 0,   0, 0, 1, 1, 0, 0, ST_RUN});
    tbl.push_back('{"fwd_m",    0,  0,  7,  0,  0, 0, 0,  7, 1,  7, 1, 1,   0, 0, 0, 0, 2, 0, ST_RUN});
    tbl.push_back('{"fwd_w",    0,  0,  7,  0,  0, 0, 0,  7, 0,  7, 1, 1,   0, 0, 0, 0, 1, 0, ST_RUN});
    tbl.push_back('{"fwd_none", 0,  0,  7,  0,  0, 0, 0,  0, 1,  0, 1, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"fwd_x0",   0,  0,  0,  0,  0, 0, 0,  0, 1,  0, 1, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"fwd_ab",   0,  0,  4,  3,  0, 0, 0,  4, 1,  3, 1, 1,   0, 0, 0, 0, 2, 1, ST_RUN});
    tbl.push_back('{"fwd_b_m",  0,  0,  0, 12,  0, 0, 0, 12, 1, 12, 1, 1,   0, 0, 0, 0, 0, 2, ST_RUN});
    tbl.push_back('{"lu_miss",  5,  0,  0,  0,  5, 1, 0,  0, 0,  0, 0, 0,   1, 1, 0, 1, 0, 0, ST_IWAIT});
    tbl.push_back('{"iw_exit",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, ST_RUN});
    tbl.push_back('{"miss",     0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0,   1, 0, 1, 0, 0, 0, ST_IWAIT});
    tbl.push_back('{"miss_fwd", 0,  0,  6,  0,  0, 0, 0,  0, 0,  6, 1, 0,   1, 0, 1, 0, 1, 0, ST_IWAIT});
    tbl.push_back('{"pc_iw",    0,  0,  0,  0,  0, 0, 1,  0, 0,  0, 0, 0,   0, 0, 1, 1, 0, 0, ST_RUN});
    tbl.push_back('{"ready",    0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 0, ST_RUN});

    // Reset with hazard-looking inputs that must all be ignored
    drive(5, 0, 7, 0, 5, 1, 0, 7, 1, 0, 0, 1);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_ctl("reset", 1, 0, 1, 1, 0, 0);
    chk("reset.stall_count", 32'(hz0.stall_count), 32'd0);
    chk("reset.state", 32'(st0), ST_BOOT);

    // Boot window: exactly four cycles of hold/flush after release
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ctl($sformatf("boot%0d", i), 1, 0, 1, 1, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_ctl("post_boot", 0, 0, 0, 0, 0, 0);
    chk("post_boot.state", 32'(st0), ST_RUN);
    chk("post_boot.stall_count", 32'(hz0.stall_count), 32'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Three-cycle instruction-memory wait, then recovery
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_ctl($sformatf("iwait%0d", i), 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      exp_cnt++;
      chk($sformatf("iwait%0d.state", i), 32'(st0), ST_IWAIT);
    end
    chk("iwait.stall_count", 32'(hz0.stall_count), 32'(exp_cnt));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_ctl("iwait_done", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("iwait_done.state", 32'(st0), ST_RUN);

    // Twenty more stalls: narrow counter must pin at 15
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    exp_cnt += 20;
    chk("sat.cnt4", 32'(hz1.stall_count), 32'd15);
    chk("sat.cnt16", 32'(hz0.stall_count), 32'(exp_cnt));
    chk("sat.state", 32'(st0), ST_IWAIT);

    // Asynchronous reset in the middle of IWAIT, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("async_rst", 1, 0, 1, 1, 0, 0);
    chk("async_rst.cnt16", 32'(hz0.stall_count), 32'd0);
    chk("async_rst.cnt4", 32'(hz1.stall_count), 32'd0);
    chk("async_rst.state", 32'(st0), ST_BOOT);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall, flush and forward sequencer for the 5-stage RISC-V pipeline.
- Drives the enable/clear controls of the fetch-decode and decode-execute pipeline registers, plus the execute-stage forwarding muxes.
- Runs a small FSM covering the post-reset pipeline drain and instruction-memory wait cycles.
- Counts stall cycles for performance debug.

Parameters:
BOOT_CYCLES, 4, number of cycles after reset release during which fetch is held and decode/execute are flushed (range 1..15)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rs1_d  in  5  rs1 field of the instruction in decode
rs2_d  in  5  rs2 field of the instruction in decode
rs1_e  in  5  rs1 of the instruction in execute
rs2_e  in  5  rs2 of the instruction in execute
rd_e  in  5  destination of the instruction in execute
mem_read_e  in  1  the instruction in execute is a load
pc_src_e  in  1  branch/jump taken, resolved in execute
rd_m  in  5  destination in memory stage
reg_write_m  in  1  memory stage writes the register file
rd_w  in  5  destination in writeback
reg_write_w  in  1  writeback writes the register file
imem_ready  in  1  instruction memory returns a valid instruction this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold fetch-decode register
flush_d  out  1  clear fetch-decode register (bubble)
flush_e  out  1  clear decode-execute register (bubble)
forward_a_e  out  2  operand A select: 00 = regfile, 01 = writeback result, 10 = memory-stage ALU result
forward_b_e  out  2  operand B select, same encoding
stall_count  out  CNT_W  stall cycles since reset, saturating

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- rst_n low:
  - state = BOOT, boot counter = 0, stall_count = 0.
  - Outputs: stall_f=1, stall_d=0, flush_d=1, flush_e=1, forward_a_e=forward_b_e=00.
  - Reset asserted mid-operation returns to these values immediately, regardless of state.
- State encoding: BOOT, RUN, IWAIT. All control outputs are combinational from state and inputs; state and counters are registered.
- BOOT:
  - stall_f=1, flush_d=1, flush_e=1, stall_d=0.
  - Boot counter increments each cycle.
  - Transition to RUN on the cycle where the counter equals BOOT_CYCLES-1, so BOOT lasts exactly BOOT_CYCLES cycles after rst_n rises.
  - Hazard inputs are ignored.
- RUN and IWAIT evaluate the following conditions:
  - load_use = mem_read_e & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d)
  - miss = ~imem_ready
- Priority (highest first):
  1. pc_src_e: flush_d=1, flush_e=1, stall_f=0, stall_d=0. PC takes the target. Next state is RUN, even if miss is set.
  2. load_use: stall_f=1, stall_d=1, flush_e=1, flush_d=0. This holds for exactly one cycle per load, since the bubble clears mem_read_e. Next state is RUN, or IWAIT if miss.
  3. miss: stall_f=1, flush_d=1, stall_d=0, flush_e=0 (back end drains). Next state is IWAIT.
  4. None of the above: all four controls 0; next state RUN.
- IWAIT has the same equations as RUN and differs only in the state label, which is used by debug. It leaves on imem_ready=1 with no load_use.
- Forwarding (combinational, in every state except BOOT, where it is 00), operand A shown; B is identical using rs2_e:
  - 10 if reg_write_m & rd_m!=0 & rd_m==rs1_e
  - else 01 if reg_write_w & rd_w!=0 & rd_w==rs1_e
  - else 00
  - The memory stage wins when both match. x0 is never forwarded.
- stall_count:
  - Increments on every rising edge where stall_f=1 and state != BOOT.
  - Saturates at all-ones and does not wrap.
  - Flush-only cycles are not counted.

Test Plan:
- Release rst_n with BOOT_CYCLES=4 -> stall_f=flush_d=flush_e=1 for exactly 4 cycles, then all 0 with imem_ready=1; stall_count stays 0.
- Load rd_e=5, mem_read_e=1, rs1_d=5 -> one cycle with stall_f=stall_d=flush_e=1, then the next cycle is clear; stall_count +1. Same stimulus with rd_e=0 -> no stall.
- pc_src_e=1 together with load_use and imem_ready=0 -> flush_d=flush_e=1, stall_f=0, next state RUN.
- rs1_e=7 with rd_m=7/reg_write_m=1 and rd_w=7/reg_write_w=1 -> forward_a_e=10. Drop reg_write_m -> 01. Set rd_m=rd_w=0 -> 00.
- imem_ready low for 3 cycles -> stall_f=flush_d=1 each cycle, state IWAIT, stall_count +3; return to RUN on the cycle imem_ready goes high.
- CNT_W=4 with 20 stall cycles -> stall_count holds 15. Pulse rst_n low mid-IWAIT -> outputs take reset values asynchronously and stall_count=0.
